// File: rtl/procyon_biu_fill_ctrl.sv
// BIU line-fill responder: fetches one cacheline as a burst of word reads on an
// in-order valid/ready memory bus and returns the assembled line with a done pulse.
module procyon_biu_fill_ctrl #(
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_DC_LINE_SIZE   = 32,
  parameter int OPTN_MEM_DATA_WIDTH = 32,
  parameter int DC_LINE_WIDTH       = OPTN_DC_LINE_SIZE * 8,
  parameter int NUM_BEATS           = DC_LINE_WIDTH / OPTN_MEM_DATA_WIDTH,
  parameter int BEAT_IDX_WIDTH      = $clog2(NUM_BEATS) + 1
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_biu_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_biu_addr,
  output logic                           o_biu_done,
  output logic [DC_LINE_WIDTH-1:0]       o_biu_data,
  output logic                           o_mem_req_valid,
  input  logic                           i_mem_req_ready,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_mem_req_addr,
  input  logic                           i_mem_rsp_valid,
  input  logic [OPTN_MEM_DATA_WIDTH-1:0] i_mem_rsp_data
);

  localparam int DC_OFFSET  = $clog2(OPTN_DC_LINE_SIZE);
  localparam int BEAT_SEL_W = $clog2(NUM_BEATS);
  localparam int BYTE_OFF   = DC_OFFSET - BEAT_SEL_W;
  localparam logic [BEAT_IDX_WIDTH-1:0] NUM_BEATS_C = BEAT_IDX_WIDTH'(NUM_BEATS);
  localparam logic [BEAT_IDX_WIDTH-1:0] LAST_IDX    = BEAT_IDX_WIDTH'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    GAP
  } state_t;

  state_t                                state_q, state_d;
  logic [OPTN_ADDR_WIDTH-DC_OFFSET-1:0]  base_q, base_d;
  logic [BEAT_IDX_WIDTH-1:0]             req_cnt_q, req_cnt_d;
  logic [BEAT_IDX_WIDTH-1:0]             rsp_cnt_q, rsp_cnt_d;
  logic [DC_LINE_WIDTH-1:0]              data_q, data_d;
  logic                                  done_q, done_d;
  logic                                  req_fire;
  logic                                  rsp_fire;
  logic                                  unused_addr_bits;

  assign unused_addr_bits = &{1'b0, i_biu_addr[DC_OFFSET-1:0]};

  assign req_fire = o_mem_req_valid & i_mem_req_ready;
  assign rsp_fire = (state_q == BUSY) & i_mem_rsp_valid & (rsp_cnt_q < req_cnt_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_biu_en) state_d = BUSY;
      BUSY:    if (rsp_fire && (rsp_cnt_q == LAST_IDX)) state_d = DONE;
      DONE:    state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  // Beat address keeps the line tag and only replaces the in-line offset, so it never carries out.
  always_comb begin
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    if ((state_q == BUSY) && (req_cnt_q < NUM_BEATS_C)) begin
      o_mem_req_valid = 1'b1;
      o_mem_req_addr  = {base_q, {DC_OFFSET{1'b0}}}
                      | (OPTN_ADDR_WIDTH'(req_cnt_q[BEAT_SEL_W-1:0]) << BYTE_OFF);
    end
  end

  always_comb begin
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    if ((state_q == IDLE) && i_biu_en) begin
      base_d    = i_biu_addr[OPTN_ADDR_WIDTH-1:DC_OFFSET];
      req_cnt_d = '0;
      rsp_cnt_d = '0;
    end
    if (req_fire) begin
      req_cnt_d = req_cnt_q + 1'b1;
    end
    if (rsp_fire) begin
      rsp_cnt_d = rsp_cnt_q + 1'b1;
      data_d[int'(rsp_cnt_q[BEAT_SEL_W-1:0]) * OPTN_MEM_DATA_WIDTH +: OPTN_MEM_DATA_WIDTH] = i_mem_rsp_data;
      done_d = (rsp_cnt_q == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      base_q    <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign o_biu_done = done_q;
  assign o_biu_data = data_q;

  // A response with nothing outstanding means the memory side broke in-order protocol.
  rsp_order_a: assert property (@(posedge clk) disable iff (!n_rst)
    ((state_q == BUSY) && i_mem_rsp_valid) |-> (rsp_cnt_q < req_cnt_q));

endmodule

// File: tb/tb_procyon_biu_fill_ctrl.sv
// Self-checking bench for procyon_biu_fill_ctrl: default 32B/32b instance plus a 64B/64b instance,
// each driven by a queue-based memory model.
module tb_procyon_biu_fill_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [63:0] data;
    int          due;
  } pend_t;

  // Instance A: default parameters.
  logic         en_a = 1'b0;
  logic [31:0]  addr_a = '0;
  logic         done_a;
  logic [255:0] data_a;
  logic         mreq_valid_a;
  logic         mreq_ready_a = 1'b0;
  logic [31:0]  mreq_addr_a;
  logic         mrsp_valid_a = 1'b0;
  logic [31:0]  mrsp_data_a = '0;

  procyon_biu_fill_ctrl dut_a (
    .clk(clk), .n_rst(n_rst),
    .i_biu_en(en_a), .i_biu_addr(addr_a),
    .o_biu_done(done_a), .o_biu_data(data_a),
    .o_mem_req_valid(mreq_valid_a), .i_mem_req_ready(mreq_ready_a), .o_mem_req_addr(mreq_addr_a),
    .i_mem_rsp_valid(mrsp_valid_a), .i_mem_rsp_data(mrsp_data_a)
  );

  // Instance B: 64-byte lines over a 64-bit bus.
  logic         en_b = 1'b0;
  logic [31:0]  addr_b = '0;
  logic         done_b;
  logic [511:0] data_b;
  logic         mreq_valid_b;
  logic         mreq_ready_b = 1'b0;
  logic [31:0]  mreq_addr_b;
  logic         mrsp_valid_b = 1'b0;
  logic [63:0]  mrsp_data_b = '0;

  procyon_biu_fill_ctrl #(.OPTN_MEM_DATA_WIDTH(64), .OPTN_DC_LINE_SIZE(64)) dut_b (
    .clk(clk), .n_rst(n_rst),
    .i_biu_en(en_b), .i_biu_addr(addr_b),
    .o_biu_done(done_b), .o_biu_data(data_b),
    .o_mem_req_valid(mreq_valid_b), .i_mem_req_ready(mreq_ready_b), .o_mem_req_addr(mreq_addr_b),
    .i_mem_rsp_valid(mrsp_valid_b), .i_mem_rsp_data(mrsp_data_b)
  );

  // Memory model A state: mode 0 = always ready, 1 = ready 1,0,0 pattern, 2 = random.
  int           mode_a = 0;
  int           delay_a = 1;
  logic [31:0]  salt_a = '0;
  int           pat_a = 0;
  pend_t        pend_a[$];
  logic [31:0]  req_log_a[$];
  bit           stalled_a = 1'b0;
  logic [31:0]  stall_addr_a = '0;
  int           stall_err_a = 0;
  int           rsp_given_a = 0;
  int           done_cnt_a = 0;
  int           done_cyc_a = 0;
  logic [255:0] done_data_a = '0;
  int           c0_a = 0;
  int           log_start_a = 0;
  int           done_before_a = 0;

  int           delay_b = 1;
  logic [31:0]  salt_b = '0;
  logic [31:0]  salt_hi_b = '0;
  pend_t        pend_b[$];
  logic [31:0]  req_log_b[$];
  bit           stalled_b = 1'b0;
  logic [31:0]  stall_addr_b = '0;
  int           stall_err_b = 0;
  int           done_cnt_b = 0;
  logic [511:0] done_data_b = '0;
  int           log_start_b = 0;
  int           done_before_b = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      pend_a.delete();
      mrsp_valid_a = 1'b0;
      mreq_ready_a = 1'b0;
      stalled_a    = 1'b0;
    end else begin
      case (mode_a)
        0:       mreq_ready_a = 1'b1;
        1:       mreq_ready_a = ((pat_a % 3) == 0);
        default: mreq_ready_a = ($urandom_range(0, 99) < 55);
      endcase
      pat_a++;
      if (stalled_a && !(mreq_valid_a && (mreq_addr_a == stall_addr_a))) stall_err_a++;
      stalled_a    = mreq_valid_a && !mreq_ready_a;
      stall_addr_a = mreq_addr_a;
      if ((pend_a.size() > 0) && (pend_a[0].due <= cyc)) begin
        mrsp_valid_a = 1'b1;
        mrsp_data_a  = pend_a[0].data[31:0];
        void'(pend_a.pop_front());
        rsp_given_a++;
      end else begin
        mrsp_valid_a = 1'b0;
        mrsp_data_a  = $urandom;
      end
      if (mreq_valid_a && mreq_ready_a) begin
        req_log_a.push_back(mreq_addr_a);
        pend_a.push_back('{data: {32'h0, mreq_addr_a ^ salt_a}, due: cyc + delay_a});
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a  = cyc;
        done_data_a = data_a;
      end
    end
  end

  always @(negedge clk) begin
    if (!n_rst) begin
      pend_b.delete();
      mrsp_valid_b = 1'b0;
      mreq_ready_b = 1'b0;
      stalled_b    = 1'b0;
    end else begin
      mreq_ready_b = ($urandom_range(0, 99) < 60);
      if (stalled_b && !(mreq_valid_b && (mreq_addr_b == stall_addr_b))) stall_err_b++;
      stalled_b    = mreq_valid_b && !mreq_ready_b;
      stall_addr_b = mreq_addr_b;
      if ((pend_b.size() > 0) && (pend_b[0].due <= cyc)) begin
        mrsp_valid_b = 1'b1;
        mrsp_data_b  = pend_b[0].data;
        void'(pend_b.pop_front());
      end else begin
        mrsp_valid_b = 1'b0;
        mrsp_data_b  = {$urandom, $urandom};
      end
      if (mreq_valid_b && mreq_ready_b) begin
        req_log_b.push_back(mreq_addr_b);
        pend_b.push_back('{data: {mreq_addr_b ^ salt_hi_b, mreq_addr_b ^ salt_b}, due: cyc + delay_b});
      end
      if (done_b) begin
        done_cnt_b++;
        done_data_b = data_b;
      end
    end
  end

  // Expected line: beat i holds the data the memory returns for line base + i*beat_bytes.
  function automatic logic [255:0] exp_line_a(input logic [31:0] addr, input logic [31:0] salt);
    logic [255:0] line;
    logic [31:0]  base;
    base = addr & ~32'h1F;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = (base + 32'(i * 4)) ^ salt;
    return line;
  endfunction

  function automatic logic [511:0] exp_line_b(input logic [31:0] addr, input logic [31:0] salt,
                                              input logic [31:0] salt_hi);
    logic [511:0] line;
    logic [31:0]  base;
    logic [31:0]  ba;
    base = addr & ~32'h3F;
    for (int i = 0; i < 8; i++) begin
      ba = base + 32'(i * 8);
      line[i*64 +: 64] = {ba ^ salt_hi, ba ^ salt};
    end
    return line;
  endfunction

  function automatic int addr_errs_a(input int start, input logic [31:0] addr);
    logic [31:0] base;
    int errs;
    base = addr & ~32'h1F;
    errs = (req_log_a.size() - start != 8) ? 1 : 0;
    for (int i = 0; i < 8; i++)
      if ((start + i >= req_log_a.size()) || (req_log_a[start+i] !== base + 32'(i * 4))) errs++;
    return errs;
  endfunction

  function automatic int addr_errs_b(input int start, input logic [31:0] addr);
    logic [31:0] base;
    int errs;
    base = addr & ~32'h3F;
    errs = (req_log_b.size() - start != 8) ? 1 : 0;
    for (int i = 0; i < 8; i++)
      if ((start + i >= req_log_b.size()) || (req_log_b[start+i] !== base + 32'(i * 8))) errs++;
    return errs;
  endfunction

  task automatic start_a(input logic [31:0] addr);
    @(negedge clk); #1;
    en_a          = 1'b1;
    addr_a        = addr;
    c0_a          = cyc;
    log_start_a   = req_log_a.size();
    done_before_a = done_cnt_a;
  endtask

  task automatic wait_done_a(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done_cnt_a != done_before_a) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_b(input logic [31:0] addr);
    @(negedge clk); #1;
    en_b          = 1'b1;
    addr_b        = addr;
    log_start_b   = req_log_b.size();
    done_before_b = done_cnt_b;
  endtask

  task automatic wait_done_b(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done_cnt_b != done_before_b) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (done_a !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done_a);
    else n_pass++;
    n_total++;
    if (mreq_valid_a !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b want 0", mreq_valid_a);
    else n_pass++;
    n_total++;
    if (mreq_addr_a !== 32'h0) $display("[TB] FAIL reset_req_addr: got %h want 0", mreq_addr_a);
    else n_pass++;
    n_total++;
    if (data_a !== 256'h0) $display("[TB] FAIL reset_data: got %h want 0", data_a);
    else n_pass++;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    logic [255:0] exp;
    mode_a = 0; delay_a = 1; salt_a = 32'h0;
    exp = exp_line_a(32'h0000_1234, 32'h0);
    start_a(32'h0000_1234);
    wait_done_a(to);
    @(negedge clk); #1;
    en_a = 1'b0;
    n_total++;
    if (to) $display("[TB] FAIL basic_timeout: no done within bound");
    else n_pass++;
    n_total++;
    if (done_cyc_a - c0_a != 10) $display("[TB] FAIL basic_latency: got %0d want 10", done_cyc_a - c0_a);
    else n_pass++;
    n_total++;
    if (done_data_a !== exp) $display("[TB] FAIL basic_data: got %h want %h", done_data_a, exp);
    else n_pass++;
    n_total++;
    if (addr_errs_a(log_start_a, 32'h0000_1234) != 0)
      $display("[TB] FAIL basic_addrs: %0d bad of %0d logged, want 0 bad", addr_errs_a(log_start_a, 32'h0000_1234),
               req_log_a.size() - log_start_a);
    else n_pass++;
    repeat (5) @(negedge clk);
    #1;
    n_total++;
    if (done_cnt_a - done_before_a != 1) $display("[TB] FAIL basic_done_once: got %0d pulses want 1", done_cnt_a - done_before_a);
    else n_pass++;
    n_total++;
    if (data_a !== exp) $display("[TB] FAIL basic_retain: got %h want %h", data_a, exp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    logic [31:0] addr;
    logic [255:0] exp;
    int serr0;
    mode_a = 1; delay_a = 3; salt_a = $urandom; pat_a = 0;
    addr = $urandom;
    exp = exp_line_a(addr, salt_a);
    serr0 = stall_err_a;
    start_a(addr);
    wait_done_a(to);
    @(negedge clk); #1;
    en_a = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_total++;
    if (to) $display("[TB] FAIL bp_timeout: no done within bound");
    else n_pass++;
    n_total++;
    if (addr_errs_a(log_start_a, addr) != 0)
      $display("[TB] FAIL bp_addrs: %0d bad of %0d logged, want 0 bad", addr_errs_a(log_start_a, addr),
               req_log_a.size() - log_start_a);
    else n_pass++;
    n_total++;
    if (stall_err_a != serr0) $display("[TB] FAIL bp_stable: %0d unstable stalls want 0", stall_err_a - serr0);
    else n_pass++;
    n_total++;
    if (done_data_a !== exp) $display("[TB] FAIL bp_data: got %h want %h", done_data_a, exp);
    else n_pass++;
    n_total++;
    if (done_cnt_a - done_before_a != 1) $display("[TB] FAIL bp_done_once: got %0d pulses want 1", done_cnt_a - done_before_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    bit early;
    logic [255:0] exp1;
    logic [255:0] exp2;
    logic [255:0] got1;
    mode_a = 0; delay_a = 1; salt_a = $urandom;
    exp1 = exp_line_a(32'h0000_1234, salt_a);
    exp2 = exp_line_a(32'h0000_2000, salt_a);
    start_a(32'h0000_1234);
    wait_done_a(to);
    got1 = done_data_a;
    n_total++;
    if (to) $display("[TB] FAIL b2b_timeout1: no done within bound");
    else n_pass++;
    n_total++;
    if (got1 !== exp1) $display("[TB] FAIL b2b_data1: got %h want %h", got1, exp1);
    else n_pass++;
    early = 1'b0;
    @(negedge clk); #1;
    if (mreq_valid_a) early = 1'b1;
    @(negedge clk); #1;
    if (mreq_valid_a) early = 1'b1;
    n_total++;
    if (early) $display("[TB] FAIL b2b_gap_ignore: request seen %0d cycles after done, want none", 2);
    else n_pass++;
    addr_a        = 32'h0000_2000;
    log_start_a   = req_log_a.size();
    done_before_a = done_cnt_a;
    @(negedge clk); #1;
    n_total++;
    if (!(mreq_valid_a === 1'b1 && mreq_addr_a === 32'h0000_2000))
      $display("[TB] FAIL b2b_first_req: got valid=%b addr=%h want valid=1 addr=00002000", mreq_valid_a, mreq_addr_a);
    else n_pass++;
    wait_done_a(to);
    @(negedge clk); #1;
    en_a = 1'b0;
    n_total++;
    if (to) $display("[TB] FAIL b2b_timeout2: no done within bound");
    else n_pass++;
    n_total++;
    if (done_data_a !== exp2) $display("[TB] FAIL b2b_data2: got %h want %h", done_data_a, exp2);
    else n_pass++;
    n_total++;
    if (addr_errs_a(log_start_a, 32'h0000_2000) != 0)
      $display("[TB] FAIL b2b_addrs2: %0d bad of %0d logged, want 0 bad", addr_errs_a(log_start_a, 32'h0000_2000),
               req_log_a.size() - log_start_a);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    bit waited;
    int r0;
    int d0;
    logic [255:0] exp;
    mode_a = 0; delay_a = 2; salt_a = $urandom | 32'h1;
    r0 = rsp_given_a;
    start_a(32'h0000_3010);
    waited = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rsp_given_a - r0 >= 3) begin
        waited = 1'b1;
        break;
      end
    end
    n_total++;
    if (!waited) $display("[TB] FAIL rst_mid_wait: got %0d responses want 3", rsp_given_a - r0);
    else n_pass++;
    @(posedge clk); #1;
    d0 = done_cnt_a;
    n_rst = 1'b0;
    #1;
    n_total++;
    if ({done_a, mreq_valid_a} !== 2'b00 || mreq_addr_a !== 32'h0 || data_a !== 256'h0)
      $display("[TB] FAIL rst_mid_outputs: got done=%b valid=%b addr=%h data=%h want all 0",
               done_a, mreq_valid_a, mreq_addr_a, data_a);
    else n_pass++;
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    n_total++;
    if (done_cnt_a != d0 || mreq_valid_a !== 1'b0)
      $display("[TB] FAIL rst_mid_no_done: got %0d pulses valid=%b want 0 pulses valid=0", done_cnt_a - d0, mreq_valid_a);
    else n_pass++;
    delay_a = 1;
    exp = exp_line_a(32'h0000_4000, salt_a);
    start_a(32'h0000_4000);
    wait_done_a(to);
    @(negedge clk); #1;
    en_a = 1'b0;
    n_total++;
    if (to || done_data_a !== exp) $display("[TB] FAIL rst_mid_refill: timeout=%b got %h want %h", to, done_data_a, exp);
    else n_pass++;
    n_total++;
    if (addr_errs_a(log_start_a, 32'h0000_4000) != 0)
      $display("[TB] FAIL rst_mid_addrs: %0d bad want 0", addr_errs_a(log_start_a, 32'h0000_4000));
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit to;
    logic [255:0] exp;
    mode_a = 0; delay_a = 1; salt_a = $urandom;
    exp = exp_line_a(32'hFFFF_FFFC, salt_a);
    start_a(32'hFFFF_FFFC);
    wait_done_a(to);
    @(negedge clk); #1;
    en_a = 1'b0;
    n_total++;
    if (to || req_log_a.size() - log_start_a < 8)
      $display("[TB] FAIL wrap_timeout: timeout=%b beats=%0d want 8", to, req_log_a.size() - log_start_a);
    else n_pass++;
    n_total++;
    if (req_log_a.size() - log_start_a >= 8 &&
        (req_log_a[log_start_a] !== 32'hFFFF_FFE0 || req_log_a[log_start_a+7] !== 32'hFFFF_FFFC))
      $display("[TB] FAIL wrap_ends: got first=%h last=%h want ffffffe0/fffffffc",
               req_log_a[log_start_a], req_log_a[log_start_a+7]);
    else n_pass++;
    n_total++;
    if (addr_errs_a(log_start_a, 32'hFFFF_FFFC) != 0)
      $display("[TB] FAIL wrap_addrs: %0d bad want 0", addr_errs_a(log_start_a, 32'hFFFF_FFFC));
    else n_pass++;
    n_total++;
    if (done_data_a !== exp) $display("[TB] FAIL wrap_data: got %h want %h", done_data_a, exp);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random_fills();
    bit to;
    logic [31:0] addr;
    logic [255:0] exp;
    for (int k = 0; k < 6; k++) begin
      mode_a  = 2;
      delay_a = $urandom_range(1, 4);
      salt_a  = $urandom;
      addr    = $urandom;
      exp     = exp_line_a(addr, salt_a);
      start_a(addr);
      wait_done_a(to);
      @(negedge clk); #1;
      en_a = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (to || done_data_a !== exp)
        $display("[TB] FAIL rand_data[%0d]: timeout=%b got %h want %h", k, to, done_data_a, exp);
      else n_pass++;
      n_total++;
      if (addr_errs_a(log_start_a, addr) != 0 || done_cnt_a - done_before_a != 1)
        $display("[TB] FAIL rand_addrs[%0d]: %0d bad addrs, %0d done pulses, want 0 and 1", k,
                 addr_errs_a(log_start_a, addr), done_cnt_a - done_before_a);
      else n_pass++;
    end
    n_total++;
    if (stall_err_a != 0) $display("[TB] FAIL rand_stable: got %0d unstable stalls want 0", stall_err_a);
    else n_pass++;
  endtask

  task automatic test_wide();
    bit to;
    logic [31:0] addr;
    logic [511:0] exp;
    for (int k = 0; k < 4; k++) begin
      delay_b   = $urandom_range(1, 3);
      salt_b    = $urandom;
      salt_hi_b = $urandom;
      addr      = (k == 0) ? 32'hFFFF_FFFC : $urandom;
      exp       = exp_line_b(addr, salt_b, salt_hi_b);
      start_b(addr);
      wait_done_b(to);
      @(negedge clk); #1;
      en_b = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (to || done_data_b !== exp)
        $display("[TB] FAIL wide_data[%0d]: timeout=%b got %h want %h", k, to, done_data_b, exp);
      else n_pass++;
      n_total++;
      if (addr_errs_b(log_start_b, addr) != 0 || done_cnt_b - done_before_b != 1)
        $display("[TB] FAIL wide_addrs[%0d]: %0d bad addrs, %0d done pulses, want 0 and 1", k,
                 addr_errs_b(log_start_b, addr), done_cnt_b - done_before_b);
      else n_pass++;
    end
    n_total++;
    if (stall_err_b != 0) $display("[TB] FAIL wide_stable: got %0d unstable stalls want 0", stall_err_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_wrap();
    test_random_fills();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
